// File: rtl/reg_file_mp.sv
// Multi-port register file with registered, write-first reads and a sequential
// clear engine that zeroes one entry per cycle after reset or on request.
module reg_file_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    i_rd_addr,
    output logic [NRD*WIDTH-1:0] o_rd_data,
    input  logic [NWR-1:0]       i_wr_en,
    input  logic [NWR*AW-1:0]    i_wr_addr,
    input  logic [NWR*WIDTH-1:0] i_wr_data,
    input  logic                 i_clear_req,
    output logic                 o_busy
);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    localparam logic [AW-1:0] LAST_ENTRY = AW'(DEPTH - 1);

    state_t                 r_state;
    logic [AW-1:0]          r_clr_ptr;
    logic                   r_busy;
    logic [NRD*WIDTH-1:0]   r_rd_data;
    logic [WIDTH-1:0]       r_mem [DEPTH];

    logic [AW-1:0]          w_rd_addr [NRD];
    logic [AW-1:0]          w_wr_addr [NWR];
    logic [WIDTH-1:0]       w_wr_data [NWR];
    logic [NWR-1:0]         w_wr_ok;
    logic [WIDTH-1:0]       w_rd_next [NRD];

    for (genvar k = 0; k < NRD; k++) begin : g_rd_unpack
        assign w_rd_addr[k] = i_rd_addr[k*AW +: AW];
    end

    for (genvar j = 0; j < NWR; j++) begin : g_wr_unpack
        assign w_wr_addr[j] = i_wr_addr[j*AW +: AW];
        assign w_wr_data[j] = i_wr_data[j*WIDTH +: WIDTH];
        assign w_wr_ok[j]   = i_wr_en[j] && !(ZERO_REG != 0 && w_wr_addr[j] == '0);
    end

    // Later ports overwrite earlier ones, so the highest-index matching writer wins.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            w_rd_next[k] = r_mem[w_rd_addr[k]];
            for (int j = 0; j < NWR; j++) begin
                if (i_wr_en[j] && w_wr_addr[j] == w_rd_addr[k]) begin
                    w_rd_next[k] = w_wr_data[j];
                end
            end
            if (ZERO_REG != 0 && w_rd_addr[k] == '0) begin
                w_rd_next[k] = '0;
            end
        end
    end

    // The array has no reset of its own; the clear engine owns its initial contents.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (w_wr_ok[j]) begin
                    r_mem[w_wr_addr[j]] <= w_wr_data[j];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_rd_data <= '0;
                    r_clr_ptr <= r_clr_ptr + AW'(1);
                    if (r_clr_ptr == LAST_ENTRY) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    for (int k = 0; k < NRD; k++) begin
                        r_rd_data[k*WIDTH +: WIDTH] <= w_rd_next[k];
                    end
                    if (i_clear_req) begin
                        r_state   <= S_CLEAR;
                        r_clr_ptr <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed vector table, hand-written clear and
// reset sequences, then random traffic checked against an array-based reference model.
module tb_reg_file_mp;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NRD*AW-1:0]    rdAddr = '0;
    logic [NRD*WIDTH-1:0] rdData;
    logic [NWR-1:0]       wrEn = '0;
    logic [NWR*AW-1:0]    wrAddr = '0;
    logic [NWR*WIDTH-1:0] wrData = '0;
    logic                 clearReq = 1'b0;
    logic                 busy;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [WIDTH-1:0] mMem [DEPTH];
    logic [WIDTH-1:0] mRd [NRD];
    int               mClearLeft;

    typedef struct {
        logic [1:0]       we;
        logic [AW-1:0]    wa0;
        logic [WIDTH-1:0] wd0;
        logic [AW-1:0]    wa1;
        logic [WIDTH-1:0] wd1;
        logic [AW-1:0]    ra0;
        logic [AW-1:0]    ra1;
        logic [WIDTH-1:0] e0;
        logic [WIDTH-1:0] e1;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    reg_file_mp #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rd_addr  (rdAddr),
        .o_rd_data  (rdData),
        .i_wr_en    (wrEn),
        .i_wr_addr  (wrAddr),
        .i_wr_data  (wrData),
        .i_clear_req(clearReq),
        .o_busy     (busy)
    );

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic void modelReset();
        mClearLeft = DEPTH;
        for (int k = 0; k < NRD; k++) mRd[k] = '0;
    endfunction

    // One clock edge of the reference: clearing counts down, otherwise read-then-write.
    function automatic void modelEdge();
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] v;
        if (mClearLeft > 0) begin
            mMem[DEPTH - mClearLeft] = '0;
            mClearLeft--;
            for (int k = 0; k < NRD; k++) mRd[k] = '0;
        end else begin
            for (int k = 0; k < NRD; k++) begin
                a = rdAddr[k*AW +: AW];
                v = mMem[a];
                for (int j = 0; j < NWR; j++)
                    if (wrEn[j] && wrAddr[j*AW +: AW] == a) v = wrData[j*WIDTH +: WIDTH];
                if (a == 0) v = '0;
                mRd[k] = v;
            end
            for (int j = 0; j < NWR; j++)
                if (wrEn[j] && wrAddr[j*AW +: AW] != 0)
                    mMem[wrAddr[j*AW +: AW]] = wrData[j*WIDTH +: WIDTH];
            if (clearReq) mClearLeft = DEPTH;
        end
    endfunction

    task automatic applyStimulus(input logic [1:0] we,
                                 input logic [AW-1:0] wa0, input logic [WIDTH-1:0] wd0,
                                 input logic [AW-1:0] wa1, input logic [WIDTH-1:0] wd1,
                                 input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                                 input logic clr);
        wrEn     = we;
        wrAddr   = {wa1, wa0};
        wrData   = {wd1, wd0};
        rdAddr   = {ra1, ra0};
        clearReq = clr;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput("busy", {31'b0, busy}, {31'b0, (mClearLeft > 0)});
        for (int k = 0; k < NRD; k++)
            checkOutput($sformatf("rd%0d", k), rdData[k*WIDTH +: WIDTH], mRd[k]);
        wrEn     = '0;
        clearReq = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(2'b00, '0, '0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic assertReset(input string tag);
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd1);
        checkOutput({tag, "_rd0"}, rdData[0 +: WIDTH], '0);
        checkOutput({tag, "_rd1"}, rdData[WIDTH +: WIDTH], '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic countBusy(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            idleCycle();
            n++;
        end
        checkOutput({tag, "_busy_len"}, n, DEPTH);
    endtask

    initial begin
        int n;
        vecs[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,      5'd1, 5'd2, 32'h0,        32'h0};
        vecs[1] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{2'b11, 5'd7, 32'h1111,     5'd7, 32'h2222,   5'd7, 5'd5, 32'h2222,     32'hDEADBEEF};
        vecs[3] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      5'd7, 5'd7, 32'h2222,     32'h2222};
        vecs[4] = '{2'b11, 5'd0, 32'hFFFFFFFF, 5'd3, 32'h33,     5'd0, 5'd3, 32'h0,        32'h33};
        vecs[5] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      5'd0, 5'd0, 32'h0,        32'h0};
        vecs[6] = '{2'b01, 5'd9, 32'h99,       5'd0, 32'h0,      5'd9, 5'd3, 32'h99,       32'h33};
        vecs[7] = '{2'b10, 5'd9, 32'h5555,     5'd9, 32'hABCD,   5'd9, 5'd9, 32'hABCD,     32'hABCD};
        vecs[8] = '{2'b11, 5'd3, 32'h3030,     5'd4, 32'h4444,   5'd3, 5'd4, 32'h3030,     32'h4444};
        vecs[9] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      5'd3, 5'd9, 32'h3030,     32'hABCD};

        #2;
        assertReset("reset");
        countBusy("init");

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
                          vecs[i].ra0, vecs[i].ra1, 1'b0);
            checkOutput($sformatf("vec%0d_rd0", i), rdData[0 +: WIDTH], vecs[i].e0);
            checkOutput($sformatf("vec%0d_rd1", i), rdData[WIDTH +: WIDTH], vecs[i].e1);
        end

        // Requested clear with a second request mid-sweep that must not extend it.
        applyStimulus(2'b00, '0, '0, '0, '0, 5'd3, 5'd9, 1'b1);
        checkOutput("clr_start_busy", {31'b0, busy}, 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            applyStimulus(2'b00, '0, '0, '0, '0, 5'd3, 5'd9, (n == 10));
            n++;
        end
        checkOutput("clr_busy_len", n, DEPTH);
        applyStimulus(2'b00, '0, '0, '0, '0, 5'd3, 5'd9, 1'b0);
        checkOutput("after_clr_rd3", rdData[0 +: WIDTH], '0);
        checkOutput("after_clr_rd9", rdData[WIDTH +: WIDTH], '0);

        // Reset while idle must drop nonzero read data at once.
        applyStimulus(2'b01, 5'd12, 32'hCAFEF00D, '0, '0, 5'd12, 5'd0, 1'b0);
        checkOutput("pre_rst_rd0", rdData[0 +: WIDTH], 32'hCAFEF00D);
        assertReset("idle_rst");
        countBusy("idle_rst");

        // Reset in the middle of a requested sweep restarts it from entry 0.
        applyStimulus(2'b00, '0, '0, '0, '0, '0, '0, 1'b1);
        repeat (12) idleCycle();
        assertReset("mid_rst");
        countBusy("mid_rst");

        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a [4];
            for (int m = 0; m < 4; m++)
                a[m] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
            applyStimulus(2'($urandom_range(0, 3)), a[0], $urandom, a[1], $urandom,
                          a[2], a[3], ($urandom_range(0, 63) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
